// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants for the MIPS32 core.
`default_nettype none

package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// pc_reg: program counter, pending-redirect target and the wrapping +4 adder.
`default_nettype none

module pc_reg
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              take_redirect,
  input  logic              take_pending,
  input  logic              save_pending,
  input  logic              clear_pending,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_inc,
  output logic              pend_valid
);

  logic [ADDR_W-1:0] pend_pc;

  // Natural modulo-2^ADDR_W wrap, no carry out kept.
  assign pc_inc = pc + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (take_redirect) begin
      pc <= redirect_target;
    end else if (take_pending) begin
      pc <= pend_pc;
    end else if (advance) begin
      pc <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (clear_pending) begin
      pend_valid <= 1'b0;
    end else if (save_pending) begin
      pend_valid <= 1'b1;
      pend_pc    <= redirect_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS32 fetch stage - PC ownership, imem req/ack and decode valid/ready.
`default_nettype none

module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               misalign
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_inc, redirect_target;
  logic              pend_valid;
  logic              advance, take_redirect, take_pending, save_pending, clear_pending;
  logic              capture;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_addr       = pc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .advance         (advance),
    .take_redirect   (take_redirect),
    .take_pending    (take_pending),
    .save_pending    (save_pending),
    .clear_pending   (clear_pending),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_inc          (pc_inc),
    .pend_valid      (pend_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    advance       = 1'b0;
    take_redirect = 1'b0;
    take_pending  = 1'b0;
    save_pending  = 1'b0;
    clear_pending = 1'b0;
    capture       = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next    = ST_FETCH;
        take_redirect = redirect_valid;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          // A redirect seen during this request invalidates the returned word;
          // the IDLE detour gives the one-cycle request gap before refetching.
          if (redirect_valid) begin
            take_redirect = 1'b1;
            clear_pending = 1'b1;
            state_next    = ST_IDLE;
          end else if (pend_valid) begin
            take_pending  = 1'b1;
            clear_pending = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            advance    = 1'b1;
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (redirect_valid) begin
          save_pending = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_next    = ST_FETCH;
        end else if (instr_ready) begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= '0;
      pc_plus4    <= '0;
      misalign    <= 1'b0;
    end else begin
      imem_req    <= (state_next == ST_FETCH);
      instr_valid <= (state_next == ST_HOLD);
      misalign    <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
        pc_plus4 <= pc_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run checked against a program-flow model.
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  logic        rst2_n;
  logic        req2, ack2, valid2, mis2;
  logic [31:0] addr2, rdata2, instr2, pc2, p4_2;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign       (misalign)
  );

  assign ack2   = req2;
  assign rdata2 = memf(addr2);

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst2_n),
    .imem_req       (req2),
    .imem_addr      (addr2),
    .imem_ack       (ack2),
    .imem_rdata     (rdata2),
    .instr_valid    (valid2),
    .instr_ready    (1'b1),
    .instr          (instr2),
    .instr_pc       (pc2),
    .pc_plus4       (p4_2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .misalign       (mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the DUT in FETCH with imem_req=1 at RESET_PC on return.
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick(); tick();
    n_cmp++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: req=%b valid=%b mis=%b want 0 0 0", imem_req, instr_valid, misalign);
    end
    n_cmp++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: instr=%h pc=%h p4=%h addr=%h want all 0", instr, instr_pc, pc_plus4, imem_addr);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    int cnt;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      cnt = 0;
      while (!imem_req && cnt < 10) begin tick(); cnt++; end
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_bad++; $display("FAIL seq_addr[%0d]: req=%b addr=%h want 1 %h", k, imem_req, imem_addr, a);
      end
      tick();
      imem_ack = 1'b1; imem_rdata = memf(a);
      tick();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== memf(a) || instr_pc !== a || pc_plus4 !== a + 32'd4) begin
        n_bad++; $display("FAIL seq_instr[%0d]: v=%b instr=%h pc=%h p4=%h want 1 %h %h %h",
                          k, instr_valid, instr, instr_pc, pc_plus4, memf(a), a, a + 32'd4);
      end
    end
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = memf(32'h0);
    tick();
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== memf(32'h0) || instr_pc !== 32'h0) begin
        n_bad++; $display("FAIL hold_stable[%0d]: v=%b req=%b instr=%h pc=%h want 1 0 %h 0",
                          k, instr_valid, imem_req, instr, instr_pc, memf(32'h0));
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_bad++; $display("FAIL hold_release: v=%b req=%b addr=%h want 0 1 00000004", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_late();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
        n_bad++; $display("FAIL late_addr_stable[%0d]: req=%b addr=%h v=%b mis=%b want 1 0 0 0",
                          k, imem_req, imem_addr, instr_valid, misalign);
      end
      if (k == 2) begin imem_ack = 1'b1; imem_rdata = memf(32'h0); end
      tick();
    end
    imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL late_discard: v=%b req=%b want 0 0", instr_valid, imem_req);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL late_refetch: req=%b addr=%h v=%b want 1 00000100 0", imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = memf(32'h100);
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memf(32'h100)) begin
      n_bad++; $display("FAIL late_new_instr: v=%b pc=%h instr=%h want 1 00000100 %h",
                        instr_valid, instr_pc, instr, memf(32'h100));
    end
  endtask

  task automatic test_misalign();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    imem_ack = 1'b1; imem_rdata = memf(32'h0);
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    n_cmp++;
    if (misalign !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL misalign_pulse: mis=%b v=%b req=%b want 1 0 0", misalign, instr_valid, imem_req);
    end
    tick();
    n_cmp++;
    if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_bad++; $display("FAIL misalign_target: mis=%b req=%b addr=%h want 0 1 00000200", misalign, imem_req, imem_addr);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    imem_ack = 1'b1; imem_rdata = memf(32'h0);
    tick();
    imem_ack = 1'b0;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_bad++; $display("FAIL hold_redirect: v=%b req=%b addr=%h want 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = memf(32'h0);
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL midreset_req_drop: req=%b want 0", imem_req);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL midreset_restart: v=%b req=%b addr=%h want 0 1 0", instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b0;
    tick();
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_valid: v=%b want 0", instr_valid);
    end
  endtask

  task automatic test_wrap();
    tick();
    rst2_n = 1'b1;
    tick();
    n_cmp++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_first_addr: req=%b addr=%h want 1 fffffffc", req2, addr2);
    end
    tick();
    n_cmp++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || p4_2 !== 32'h0 || instr2 !== memf(32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL wrap_instr: v=%b pc=%h p4=%h instr=%h want 1 fffffffc 0 %h",
                        valid2, pc2, p4_2, instr2, memf(32'hFFFF_FFFC));
    end
    tick();
    n_cmp++;
    if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      n_bad++; $display("FAIL wrap_next_addr: req=%b addr=%h want 1 0", req2, addr2);
    end
    rst2_n = 1'b0;
  endtask

  // Model tracks program flow: the next address the program should fetch, words
  // owed to decode, and whether the in-flight request has been made stale.
  task automatic test_random();
    logic [31:0] exp_pc, req_addr, a, sh_instr, sh_pc;
    logic [31:0] owed[$];
    bit in_req, squash, shown, exp_mis, exp_valid_next, drop_next, redir;
    int lat;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    exp_pc = 32'h0; req_addr = 32'h0; sh_instr = 32'h0; sh_pc = 32'h0;
    in_req = 0; squash = 0; shown = 0; exp_mis = 0; exp_valid_next = 0; drop_next = 0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      n_cmp++;
      if (misalign !== exp_mis) begin
        n_bad++; $display("FAIL rnd_misalign @%0d: got %b want %b", cyc, misalign, exp_mis);
      end
      if (exp_valid_next) begin
        n_cmp++;
        if (instr_valid !== 1'b1) begin
          n_bad++; $display("FAIL rnd_latency @%0d: valid=%b want 1", cyc, instr_valid);
        end
      end
      if (drop_next) begin
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
          n_bad++; $display("FAIL rnd_discard @%0d: req=%b v=%b want 0 0", cyc, imem_req, instr_valid);
        end
      end
      if (instr_valid === 1'b1) begin
        n_cmp++;
        if (imem_req !== 1'b0) begin
          n_bad++; $display("FAIL rnd_overlap @%0d: req=%b while valid, want 0", cyc, imem_req);
        end
        if (!shown) begin
          n_cmp++;
          if (owed.size() == 0) begin
            n_bad++; $display("FAIL rnd_spurious @%0d: valid pc=%h with nothing owed", cyc, instr_pc);
          end else begin
            a = owed.pop_front();
            if (instr_pc !== a || instr !== memf(a) || pc_plus4 !== a + 32'd4) begin
              n_bad++; $display("FAIL rnd_instr @%0d: pc=%h instr=%h p4=%h want %h %h %h",
                                cyc, instr_pc, instr, pc_plus4, a, memf(a), a + 32'd4);
            end
          end
          shown = 1; sh_instr = instr; sh_pc = instr_pc;
        end else begin
          n_cmp++;
          if (instr !== sh_instr || instr_pc !== sh_pc) begin
            n_bad++; $display("FAIL rnd_hold_stable @%0d: instr=%h pc=%h want %h %h", cyc, instr, instr_pc, sh_instr, sh_pc);
          end
        end
      end
      if (imem_req === 1'b1) begin
        n_cmp++;
        if (!in_req) begin
          in_req = 1; squash = 0; req_addr = exp_pc; lat = $urandom_range(0, 3);
          if (imem_addr !== exp_pc) begin
            n_bad++; $display("FAIL rnd_fetch_addr @%0d: got %h want %h", cyc, imem_addr, exp_pc);
          end
        end else if (imem_addr !== req_addr) begin
          n_bad++; $display("FAIL rnd_addr_stable @%0d: got %h want %h", cyc, imem_addr, req_addr);
        end
      end

      exp_valid_next = 0; drop_next = 0;
      redir = ($urandom_range(0, 7) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = redir;
      if (!redir) redirect_pc = 32'h0;
      else if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = 32'($urandom_range(0, 4095));
      exp_mis = redir && (redirect_pc[1:0] != 2'b00);
      imem_ack = 1'b0; imem_rdata = $urandom;
      if (in_req && imem_req === 1'b1) begin
        if (lat == 0) begin
          imem_ack = 1'b1; imem_rdata = memf(req_addr); in_req = 0;
          if (squash || redir) begin
            drop_next = 1;
          end else begin
            owed.push_back(req_addr); exp_valid_next = 1; exp_pc = req_addr + 32'd4;
          end
        end else begin
          lat--;
        end
      end
      if (redir) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
        if (in_req) squash = 1;
      end
      if (instr_valid === 1'b1 && (instr_ready || redir)) shown = 0;
    end
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_late();
    test_misalign();
    test_hold_redirect();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
